// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants and state type for the round-robin arbiter
package rr_arb_pkg;

   localparam int NREQ = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/decoder2to4_en.sv
// rtl/decoder2to4_en.sv - enabled 2-to-4 one-hot decoder
module decoder2to4_en (
   input  logic       e,
   input  logic [1:0] a,
   output logic [3:0] y
);

   always_comb begin
      y = 4'b0000;
      if (e) y = 4'b0001 << a;
   end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// rtl/rr_arb4_ctrl.sv - four-way round-robin arbiter with per-grant hold timeout
module rr_arb4_ctrl
   import rr_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       busy,
   output logic       timeout
);

   state_t             state, state_nxt;
   logic [1:0]         ptr, ptr_nxt;
   logic [CNT_W-1:0]   hold_cnt, cnt_nxt;
   logic [1:0]         idx_nxt;
   logic               en_nxt;
   logic               to_nxt;
   logic [3:0]         gnt_nxt;

   // Walk from the highest offset down so the lowest offset from p wins.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      rr_pick = p;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = p + 2'(k);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      cnt_nxt   = hold_cnt;
      idx_nxt   = gnt_idx;
      en_nxt    = 1'b0;
      to_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|req) begin
               idx_nxt   = rr_pick(req, ptr);
               en_nxt    = 1'b1;
               cnt_nxt   = '0;
               state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            // An owner dropping its request on the last hold cycle is a release, not a timeout.
            if (!req[gnt_idx] || hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
               state_nxt = ST_IDLE;
               ptr_nxt   = gnt_idx + 2'd1;
               to_nxt    = req[gnt_idx];
            end else begin
               en_nxt  = 1'b1;
               cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   decoder2to4_en u_dec (
      .e (en_nxt),
      .a (idx_nxt),
      .y (gnt_nxt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         ptr      <= 2'd0;
         hold_cnt <= '0;
         gnt_idx  <= 2'd0;
         gnt      <= 4'b0000;
         busy     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= cnt_nxt;
         gnt_idx  <= idx_nxt;
         gnt      <= gnt_nxt;
         busy     <= en_nxt;
         timeout  <= to_nxt;
      end
   end

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// tb/tb_rr_arb4_ctrl.sv - directed vector bench for rr_arb4_ctrl
module tb_rr_arb4_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req_a = 4'b0, req_b = 4'b0, req_c = 4'b0;
   logic [3:0] gnt_a, gnt_b, gnt_c;
   logic [1:0] idx_a, idx_b, idx_c;
   logic       busy_a, busy_b, busy_c;
   logic       to_a, to_b, to_c;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rr_arb4_ctrl #(.MAX_HOLD(4), .CNT_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a),
      .gnt_idx(idx_a), .busy(busy_a), .timeout(to_a)
   );
   rr_arb4_ctrl #(.MAX_HOLD(2), .CNT_W(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b),
      .gnt_idx(idx_b), .busy(busy_b), .timeout(to_b)
   );
   rr_arb4_ctrl #(.MAX_HOLD(1), .CNT_W(8)) dut_c (
      .clk(clk), .rst_n(rst_n), .req(req_c), .gnt(gnt_c),
      .gnt_idx(idx_c), .busy(busy_c), .timeout(to_c)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       to;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [3:0] r, input logic [3:0] g, input logic [1:0] i, input logic t);
      vec_t v;
      v.req = r; v.gnt = g; v.idx = i; v.to = t;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   initial begin
      logic [3:0] eg;
      for (int i = 0; i < 5; i++) add(4'b0000, 4'b0000, 2'd0, 1'b0);
      for (int i = 0; i < 3; i++) add(4'b0100, 4'b0100, 2'd2, 1'b0);
      add(4'b0000, 4'b0000, 2'd0, 1'b0);
      add(4'b1001, 4'b1000, 2'd3, 1'b0);
      add(4'b0001, 4'b0000, 2'd0, 1'b0);
      add(4'b0001, 4'b0001, 2'd0, 1'b0);
      add(4'b1111, 4'b0001, 2'd0, 1'b0);
      add(4'b1111, 4'b0001, 2'd0, 1'b0);
      add(4'b1110, 4'b0000, 2'd0, 1'b0);
      for (int i = 0; i < 4; i++) add(4'b1111, 4'b0010, 2'd1, 1'b0);
      add(4'b1101, 4'b0000, 2'd0, 1'b0);
      for (int i = 0; i < 4; i++) add(4'b1111, 4'b0100, 2'd2, 1'b0);
      add(4'b1111, 4'b0000, 2'd0, 1'b1);
      add(4'b1111, 4'b1000, 2'd3, 1'b0);
      add(4'b1111, 4'b1000, 2'd3, 1'b0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("reset_gnt", {4'b0, gnt_a}, 8'h00);
      chk("reset_busy", {7'b0, busy_a}, 8'h00);
      chk("reset_timeout", {7'b0, to_a}, 8'h00);
      chk("reset_idx", {6'b0, idx_a}, 8'h00);

      foreach (vecs[n]) begin
         req_a = vecs[n].req;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_gnt", n), {4'b0, gnt_a}, {4'b0, vecs[n].gnt});
         chk($sformatf("vec%0d_busy", n), {7'b0, busy_a}, {7'b0, |vecs[n].gnt});
         chk($sformatf("vec%0d_timeout", n), {7'b0, to_a}, {7'b0, vecs[n].to});
         if (vecs[n].gnt != 4'b0000)
            chk($sformatf("vec%0d_idx", n), {6'b0, idx_a}, {6'b0, vecs[n].idx});
      end

      // Asynchronous reset between clock edges while requester 3 owns the grant.
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_gnt", {4'b0, gnt_a}, 8'h00);
      chk("async_rst_busy", {7'b0, busy_a}, 8'h00);
      chk("async_rst_timeout", {7'b0, to_a}, 8'h00);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req_a = 4'b1111;
      @(posedge clk);
      #1;
      chk("post_rst_gnt", {4'b0, gnt_a}, 8'h01);
      chk("post_rst_idx", {6'b0, idx_a}, 8'h00);
      req_a = 4'b0000;

      // Continuous full request: MAX_HOLD=2 and MAX_HOLD=1 rotations.
      req_b = 4'b1111;
      req_c = 4'b1111;
      for (int c = 0; c < 13; c++) begin
         @(posedge clk);
         #1;
         eg = (c % 3 < 2) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
         chk($sformatf("rr2_c%0d_gnt", c), {4'b0, gnt_b}, {4'b0, eg});
         chk($sformatf("rr2_c%0d_timeout", c), {7'b0, to_b}, {7'b0, (c % 3 == 2)});
         eg = (c % 2 == 0) ? (4'b0001 << ((c / 2) % 4)) : 4'b0000;
         chk($sformatf("rr1_c%0d_gnt", c), {4'b0, gnt_c}, {4'b0, eg});
         chk($sformatf("rr1_c%0d_timeout", c), {7'b0, to_c}, {7'b0, (c % 2 == 1)});
         chk($sformatf("rr1_c%0d_busy", c), {7'b0, busy_c}, {7'b0, (c % 2 == 0)});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
